uart_rx_fifo: RTL and testbench

Serial receive front end that consumes the `utxd_o` line driven by the APB UART and turns it back into bytes. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) at a fixed clocks-per-bit ratio. Received bytes are buffered in a small first-word-fall-through FIFO behind a valid/ready handshake. It is synthesizable, sits directly downstream of the UART transmitter, and is reused in loopback benches to check transmitted traffic.

---
 rtl/uart_rx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 serial receiver feeding a first-word-fall-through byte FIFO
module uart_rx_fifo #(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          rxd_i,
    output logic [7:0]                    rx_data_o,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int CNTW = $clog2(BAUD_DIV);
    localparam logic [CNTW-1:0] HALF_M1 = CNTW'(BAUD_DIV / 2 - 1);
    localparam logic [CNTW-1:0] FULL_M1 = CNTW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bitidx_q, bitidx_d;
    logic [7:0]        shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic              full;
    logic              rxd_s;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;

    assign rxd_s = sync_q[1];
    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = rx_valid_o && rx_ready_i;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], rxd_i};
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bitidx_d    = bitidx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        overflow_d  = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxd_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d    = '0;
                    bitidx_d = '0;
                    state_d  = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d             = '0;
                    shift_d[bitidx_q] = rxd_s;
                    if (bitidx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitidx_d = bitidx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        state_d = IDLE;
                        // A pop on this same edge frees the slot the new byte needs.
                        if (!full || pop) begin
                            push = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign rx_data_o   = mem_q[rptr_q];
    assign rx_valid_o  = (count_q != '0);
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
    assign fifo_cnt_o  = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int D     = 16;
    localparam int DEPTH = 8;
    localparam int STOP_EDGE = 2 + D / 2 + 9 * D;

    logic       clk = 1'b0;
    logic       rst_ = 1'b1;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic [3:0] fifo_cnt;

    uart_rx_fifo #(.BAUD_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .rxd_i       (rxd),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (rx_ready),
        .frame_err_o (frame_err),
        .overflow_o  (overflow),
        .fifo_cnt_o  (fifo_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fe_seen = 0;
    int ov_seen = 0;
    int rise_cyc = -1;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_cnt;
        int         exp_ov;
        int         exp_fe;
        bit         exp_push;
    } vec_t;
    vec_t vecs [9];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (frame_err) fe_seen++;
        if (overflow) ov_seen++;
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Drives one frame starting at a negedge; optionally pops exactly in the stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < D; j++) begin
                rxd = bits[i];
                if (pop_at_stop) begin
                    if (i * D + j == STOP_EDGE) begin
                        if (exp_q.size() > 0) chk("stop_pop_data", rx_data, exp_q.pop_front());
                        else chk("stop_pop_sb_empty", exp_q.size(), 1);
                        rx_ready = 1'b1;
                    end else begin
                        rx_ready = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        rx_ready = 1'b0;
    endtask

    task automatic pop_check();
        chk("pop_valid", rx_valid, 1);
        if (exp_q.size() > 0) chk("pop_data", rx_data, exp_q.pop_front());
        else chk("pop_sb_empty", exp_q.size(), 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 2 && rx_valid; k++) pop_check();
        chk("drain_sb_left", exp_q.size(), 0);
        chk("drain_valid", rx_valid, 0);
        chk("drain_cnt", fifo_cnt, 0);
    endtask

    initial begin
        int start_cyc;
        int fe_base;
        int ov_base;

        for (int k = 0; k < 9; k++) begin
            vecs[k].data     = 8'(k);
            vecs[k].stop     = 1'b1;
            vecs[k].exp_cnt  = (k < DEPTH) ? k + 1 : DEPTH;
            vecs[k].exp_ov   = (k < DEPTH) ? 0 : 1;
            vecs[k].exp_fe   = 0;
            vecs[k].exp_push = (k < DEPTH);
        end

        repeat (3) @(negedge clk);
        rst_ = 1'b0;
        @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_cnt", fifo_cnt, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ov", overflow, 0);
        repeat (2 * D) @(negedge clk);

        // Single frame latency and single pop.
        start_cyc = cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_rise_edge", rise_cyc - start_cyc, STOP_EDGE + 1);
        chk("a5_cnt", fifo_cnt, 1);
        chk("a5_data", rx_data, 8'hA5);
        pop_check();
        chk("a5_cnt_after_pop", fifo_cnt, 0);
        chk("a5_valid_after_pop", rx_valid, 0);

        // Back-to-back frames into a full FIFO.
        fe_base = fe_seen;
        ov_base = ov_seen;
        for (int k = 0; k < 9; k++) begin
            if (vecs[k].exp_push) exp_q.push_back(vecs[k].data);
            send_frame(vecs[k].data, vecs[k].stop, 1'b0);
            chk("vec_cnt", fifo_cnt, vecs[k].exp_cnt);
            chk("vec_ov", ov_seen - ov_base, vecs[k].exp_ov);
            chk("vec_fe", fe_seen - fe_base, vecs[k].exp_fe);
        end
        drain();

        // Full FIFO with a pop exactly on the stop-sample edge.
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(8'(8'h10 + k));
            send_frame(8'(8'h10 + k), 1'b1, 1'b0);
        end
        chk("full_cnt", fifo_cnt, DEPTH);
        ov_base = ov_seen;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        chk("simul_ov", ov_seen - ov_base, 0);
        chk("simul_cnt", fifo_cnt, DEPTH);
        drain();

        // Framing error followed by a long break, then a clean frame.
        fe_base = fe_seen;
        ov_base = ov_seen;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (40 * D) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * D) @(negedge clk);
        chk("brk_fe", fe_seen - fe_base, 1);
        chk("brk_cnt", fifo_cnt, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        chk("brk_after_cnt", fifo_cnt, 1);
        chk("brk_after_data", rx_data, 8'h11);
        chk("brk_after_fe", fe_seen - fe_base, 1);

        // Start-bit glitch is rejected silently.
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * D) @(negedge clk);
        chk("glitch_cnt", fifo_cnt, 1);
        chk("glitch_fe", fe_seen - fe_base, 1);
        chk("glitch_ov", ov_seen - ov_base, 0);

        // Reset in the middle of bit 4 of 0xFF, with one byte still buffered.
        rxd = 1'b0;
        repeat (D) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * D + D / 2) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        exp_q.delete();
        chk("midrst_valid", rx_valid, 0);
        chk("midrst_cnt", fifo_cnt, 0);
        chk("midrst_data", rx_data, 0);
        chk("midrst_fe", frame_err, 0);
        chk("midrst_ov", overflow, 0);
        repeat (6 * D) @(negedge clk);
        chk("midrst_no_push", fifo_cnt, 0);
        chk("midrst_no_pulse", fe_seen - fe_base + ov_seen - ov_base, 1);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 1'b0);
        chk("post_rst_cnt", fifo_cnt, 1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
